ftoi_pipe: RTL

FTOI_PIPE -- requirements
Module: ftoi_pipe

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/ftoi_shift.sv | 31 +++
 rtl/ftoi_pipe.sv | 106 ++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared float-to-int constants and the IEEE-754 single-precision field layout.
package fpu_pkg;

  localparam int          EXP_BIAS  = 127;
  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;
  localparam int          TAG_W     = 5;

  // Exponent landmarks: |x| >= 0.5, integer-exact (no fraction bits left), always-saturating.
  localparam logic [7:0] EXP_HALF    = 8'(EXP_BIAS - 1);
  localparam logic [7:0] EXP_EXACT   = 8'(EXP_BIAS + 23);
  localparam logic [7:0] EXP_SAT     = 8'(EXP_BIAS + 32);
  localparam logic [7:0] EXP_SPECIAL = 8'hFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float_t;

endpackage

// File: rtl/ftoi_shift.sv
// Aligns the 24-bit significand to an integer magnitude and reports the first bit shifted out.
module ftoi_shift
  import fpu_pkg::*;
(
  input  logic [7:0]  exp,
  input  logic [23:0] sig,
  output logic [31:0] mag,
  output logic        guard
);

  logic [4:0]  sh_r;
  logic [3:0]  sh_l;
  logic [24:0] right_q;

  always_comb begin
    sh_r    = 5'(EXP_EXACT - exp);
    sh_l    = 4'(exp - EXP_EXACT);
    // An extra low bit catches the last bit shifted out as the guard.
    right_q = {sig, 1'b0} >> sh_r;
    mag     = '0;
    guard   = 1'b0;
    if (exp >= EXP_HALF && exp < EXP_EXACT) begin
      mag   = {8'b0, right_q[24:1]};
      guard = right_q[0];
    end else if (exp >= EXP_EXACT && exp < EXP_SAT) begin
      // e = 158 yields magnitudes >= 2^31, left for the saturation stage to judge.
      mag = {8'b0, sig} << sh_l;
    end
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage float32 -> int32 converter, round to nearest (ties away), saturating.
module ftoi_pipe
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      adata,
  input  logic             flag_in,
  input  logic [TAG_W-1:0] address_in,
  output logic [31:0]      result,
  output logic             flag_out,
  output logic [TAG_W-1:0] address_out,
  output logic             invalid_out
);

  float_t op;
  assign op = adata;

  logic             s1_sign_reg;
  logic [7:0]       s1_exp_reg;
  logic [23:0]      s1_sig_reg;
  logic             s1_zero_reg;
  logic             s1_nan_reg;
  logic             s1_inf_reg;
  logic             s1_flag_reg;
  logic [TAG_W-1:0] s1_addr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sign_reg <= 1'b0;
      s1_exp_reg  <= '0;
      s1_sig_reg  <= '0;
      s1_zero_reg <= 1'b0;
      s1_nan_reg  <= 1'b0;
      s1_inf_reg  <= 1'b0;
      s1_flag_reg <= 1'b0;
      s1_addr_reg <= '0;
    end else begin
      s1_sign_reg <= op.sign;
      s1_exp_reg  <= op.exp;
      s1_sig_reg  <= {1'b1, op.frac};
      s1_zero_reg <= (op.exp == 8'd0);
      s1_nan_reg  <= (op.exp == EXP_SPECIAL) && (op.frac != '0);
      s1_inf_reg  <= (op.exp == EXP_SPECIAL) && (op.frac == '0);
      s1_flag_reg <= flag_in;
      s1_addr_reg <= address_in;
    end
  end

  logic [31:0] mag;
  logic        guard;
  logic [31:0] mag_rnd;
  logic [31:0] result_next;
  logic        invalid_next;

  ftoi_shift u_shift (
    .exp   (s1_exp_reg),
    .sig   (s1_sig_reg),
    .mag   (mag),
    .guard (guard)
  );

  assign mag_rnd = mag + {31'b0, guard};

  always_comb begin
    result_next  = '0;
    invalid_next = 1'b0;
    if (s1_nan_reg) begin
      result_next  = INT32_MAX;
      invalid_next = 1'b1;
    end else if (s1_inf_reg || s1_exp_reg >= EXP_SAT) begin
      result_next  = s1_sign_reg ? INT32_MIN : INT32_MAX;
      invalid_next = 1'b1;
    end else if (s1_zero_reg) begin
      result_next = '0;
    end else if (!s1_sign_reg) begin
      if (mag_rnd[31]) begin
        result_next  = INT32_MAX;
        invalid_next = 1'b1;
      end else begin
        result_next = mag_rnd;
      end
    end else if (mag_rnd > INT32_MIN) begin
      result_next  = INT32_MIN;
      invalid_next = 1'b1;
    end else begin
      // Exactly 2^31 negates onto itself, giving INT32_MIN without overflow.
      result_next = -mag_rnd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result      <= '0;
      invalid_out <= 1'b0;
      flag_out    <= 1'b0;
      address_out <= '0;
    end else begin
      result      <= result_next;
      invalid_out <= invalid_next;
      flag_out    <= s1_flag_reg;
      address_out <= s1_addr_reg;
    end
  end

endmodule
